// File: rtl/dyser_pkg.sv
// Shared state encoding, conf word fields and widths
// for the function-unit issue controller.
`ifndef DYSER_DATA_W
`define DYSER_DATA_W 32
`endif

package dyser_pkg;

    localparam int DATA_W = `DYSER_DATA_W;
    localparam int CONF_W = 16;
    localparam int CNT_W  = 16;

    localparam int CONF_EN_LO = 0;
    localparam int CONF_EN_HI = 1;
    localparam int CONF_OP_LO = 4;
    localparam int CONF_OP_HI = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_XOR = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_SUB = 4'd4
    } fu_op_t;

    // A zero enable field means the unit stays unconfigured.
    function automatic logic conf_enabled(
        input logic [CONF_W-1:0] c
    );
        return c[CONF_EN_HI:CONF_EN_LO] != 2'b00;
    endfunction

endpackage

// File: rtl/comp_logic.sv
// Combinational function-unit datapath selected by the
// opcode field of the configuration word.
module comp_logic
    import dyser_pkg::*;
(
    input  logic              ready_in,
    input  logic [CONF_W-1:0] conf,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              done
);

    fu_op_t w_op;
    logic   w_unused_conf;

    assign w_op = fu_op_t'(conf[CONF_OP_HI:CONF_OP_LO]);
    assign w_unused_conf = ^{conf[CONF_W-1:CONF_OP_HI+1],
                             conf[CONF_OP_LO-1:0]};
    assign done = ready_in;

    always_comb begin
        result = a + b;
        unique case (w_op)
            OP_ADD:  result = a + b;
            OP_XOR:  result = a ^ b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_SUB:  result = a - b;
            default: result = a + b;
        endcase
    end

endmodule

// File: rtl/fu_fifo.sv
// Small synchronous FIFO used for operand and result
// buffering; caller guarantees push only with space.
module fu_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (i_pop)  r_rptr <= r_rptr + 1'b1;
            if (i_push && !i_pop)
                r_cnt <= r_cnt + 1'b1;
            else if (!i_push && i_pop)
                r_cnt <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wptr] <= i_din;
    end

    assign o_dout  = r_mem[r_rptr];
    assign o_full  = (r_cnt == DEPTH[AW:0]);
    assign o_empty = (r_cnt == '0);

endmodule

// File: rtl/fu_issue_ctrl.sv
// Issue controller: buffers left/right operands, fires the
// FU when both heads meet, and sequences reconfiguration.
module fu_issue_ctrl
    import dyser_pkg::*;
#(
    parameter int IN_DEPTH  = 2,
    parameter int OUT_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              conf_valid,
    input  logic [CONF_W-1:0] conf_data,
    output logic              conf_ready,
    input  logic              l_valid,
    input  logic [DATA_W-1:0] l_data,
    output logic              l_ready,
    input  logic              r_valid,
    input  logic [DATA_W-1:0] r_data,
    output logic              r_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  fire_cnt
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CONF_W-1:0] r_conf;
    logic [CONF_W-1:0] w_conf_nxt;
    logic [CNT_W-1:0]  r_fire_cnt;

    logic              w_l_full, w_l_empty;
    logic              w_r_full, w_r_empty;
    logic              w_o_full, w_o_empty;
    logic [DATA_W-1:0] w_l_head, w_r_head;
    logic [DATA_W-1:0] w_fu_result;
    logic              w_fu_done_unused;
    logic              w_l_push, w_r_push;
    logic              w_o_pop, w_fire;

    assign w_l_push = l_valid && l_ready;
    assign w_r_push = r_valid && r_ready;
    assign w_o_pop  = out_valid && out_ready;

    // A full result buffer may still accept when it pops.
    assign w_fire = (r_state != ST_IDLE) && !w_l_empty &&
                    !w_r_empty && (!w_o_full || w_o_pop);

    assign out_valid = !rst && !w_o_empty;
    assign busy      = !rst && ((r_state != ST_IDLE) ||
                       !w_l_empty || !w_r_empty || !w_o_empty);
    assign fire_cnt  = r_fire_cnt;

    always_comb begin
        w_state_nxt = r_state;
        w_conf_nxt  = r_conf;
        conf_ready  = 1'b0;
        l_ready     = 1'b0;
        r_ready     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                conf_ready = 1'b1;
                if (conf_valid && conf_enabled(conf_data)) begin
                    w_conf_nxt  = conf_data;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                l_ready = !w_l_full;
                r_ready = !w_r_full;
                if (conf_valid) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                conf_ready = w_l_empty && w_r_empty && w_o_empty;
                if (conf_valid && conf_ready) begin
                    w_conf_nxt  = conf_data;
                    w_state_nxt = conf_enabled(conf_data) ?
                                  ST_RUN : ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (rst) begin
            conf_ready = 1'b1;
            l_ready    = 1'b0;
            r_ready    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_conf     <= '0;
            r_fire_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_conf  <= w_conf_nxt;
            if (w_fire) r_fire_cnt <= r_fire_cnt + 1'b1;
        end
    end

    fu_fifo #(.DEPTH(IN_DEPTH), .WIDTH(DATA_W)) u_l_fifo (
        .clk    (clk),
        .rst    (rst),
        .i_push (w_l_push),
        .i_din  (l_data),
        .i_pop  (w_fire),
        .o_dout (w_l_head),
        .o_full (w_l_full),
        .o_empty(w_l_empty)
    );

    fu_fifo #(.DEPTH(IN_DEPTH), .WIDTH(DATA_W)) u_r_fifo (
        .clk    (clk),
        .rst    (rst),
        .i_push (w_r_push),
        .i_din  (r_data),
        .i_pop  (w_fire),
        .o_dout (w_r_head),
        .o_full (w_r_full),
        .o_empty(w_r_empty)
    );

    fu_fifo #(.DEPTH(OUT_DEPTH), .WIDTH(DATA_W)) u_o_fifo (
        .clk    (clk),
        .rst    (rst),
        .i_push (w_fire),
        .i_din  (w_fu_result),
        .i_pop  (w_o_pop),
        .o_dout (out_data),
        .o_full (w_o_full),
        .o_empty(w_o_empty)
    );

    comp_logic u_fu (
        .ready_in(w_fire),
        .conf    (r_conf),
        .a       (w_l_head),
        .b       (w_r_head),
        .result  (w_fu_result),
        .done    (w_fu_done_unused)
    );

endmodule

// File: tb/tb_fu_issue_ctrl.sv
// Directed bench for fu_issue_ctrl with default depths;
// each scenario task checks its own expected values.
module tb_fu_issue_ctrl;

    logic        clk;
    logic        rst;
    logic        conf_valid;
    logic [15:0] conf_data;
    logic        conf_ready;
    logic        l_valid;
    logic [31:0] l_data;
    logic        l_ready;
    logic        r_valid;
    logic [31:0] r_data;
    logic        r_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic        busy;
    logic [15:0] fire_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int l_start = 0;
    int r_start = 0;
    logic [31:0] lq[$];
    logic [31:0] rq[$];
    logic [31:0] got[$];
    int got_cyc[$];

    fu_issue_ctrl #(.IN_DEPTH(2), .OUT_DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .conf_valid(conf_valid),
        .conf_data (conf_data),
        .conf_ready(conf_ready),
        .l_valid   (l_valid),
        .l_data    (l_data),
        .l_ready   (l_ready),
        .r_valid   (r_valid),
        .r_data    (r_data),
        .r_ready   (r_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .fire_cnt  (fire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        conf_valid = 1'b0;
        conf_data = '0;
        l_valid = 1'b0;
        l_data = '0;
        r_valid = 1'b0;
        r_data = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        lq.delete();
        rq.delete();
        got.delete();
        got_cyc.delete();
        l_start = 0;
        r_start = 0;
    endtask

    task automatic configure(input logic [15:0] c);
        conf_valid = 1'b1;
        conf_data = c;
        tick();
        conf_valid = 1'b0;
    endtask

    // Drives queued operands and collects popped results.
    task automatic run_cycles(input int n);
        logic la, ra;
        for (int i = 0; i < n; i++) begin
            l_valid = (lq.size() > 0) && (cyc >= l_start);
            l_data = l_valid ? lq[0] : '0;
            r_valid = (rq.size() > 0) && (cyc >= r_start);
            r_data = r_valid ? rq[0] : '0;
            #1;
            la = l_valid && l_ready;
            ra = r_valid && r_ready;
            if (out_valid && out_ready) begin
                got.push_back(out_data);
                got_cyc.push_back(cyc);
            end
            tick();
            if (la) void'(lq.pop_front());
            if (ra) void'(rq.pop_front());
        end
        l_valid = 1'b0;
        r_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        conf_valid = 1'b0;
        l_valid = 1'b0;
        r_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_out_valid got %b want 0", out_valid);
        end
        checks++;
        if ({l_ready, r_ready} !== 2'b00) begin
            errors++;
            $display("FAIL rst_ready got %b want 00",
                     {l_ready, r_ready});
        end
        checks++;
        if (conf_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_conf_ready got %b want 1", conf_ready);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_busy got %b want 0", busy);
        end
        checks++;
        if (fire_cnt !== 16'd0) begin
            errors++;
            $display("FAIL rst_fire_cnt got %0d want 0", fire_cnt);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({conf_ready, busy, l_ready} !== 3'b100) begin
            errors++;
            $display("FAIL post_rst got %b want 100",
                     {conf_ready, busy, l_ready});
        end
        // Enable field of zero must keep the unit idle.
        configure(16'h0000);
        checks++;
        if ({busy, l_ready, conf_ready} !== 3'b001) begin
            errors++;
            $display("FAIL conf_zero_idle got %b want 001",
                     {busy, l_ready, conf_ready});
        end
    endtask

    task automatic test_add();
        do_reset();
        configure(16'h0203);
        out_ready = 1'b1;
        l_valid = 1'b1;
        l_data = 32'd5;
        r_valid = 1'b1;
        r_data = 32'd7;
        checks++;
        if ({l_ready, r_ready, busy} !== 3'b111) begin
            errors++;
            $display("FAIL add_ready got %b want 111",
                     {l_ready, r_ready, busy});
        end
        tick();
        l_valid = 1'b0;
        r_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_early got %b want 0", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'd12) begin
            errors++;
            $display("FAIL add_result got %b/%0d want 1/12",
                     out_valid, out_data);
        end
        checks++;
        if (fire_cnt !== 16'd1) begin
            errors++;
            $display("FAIL add_fire_cnt got %0d want 1", fire_cnt);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_pop got %b want 0", out_valid);
        end
    endtask

    task automatic test_in_order();
        logic [31:0] exp [3];
        exp[0] = 32'd11;
        exp[1] = 32'd22;
        exp[2] = 32'd33;
        do_reset();
        configure(16'h0203);
        out_ready = 1'b1;
        lq = '{32'd1, 32'd2, 32'd3};
        rq = '{32'd10, 32'd20, 32'd30};
        r_start = cyc + 10;
        run_cycles(4);
        checks++;
        if (l_ready !== 1'b0 || lq.size() != 1) begin
            errors++;
            $display("FAIL order_lfull got %b/%0d want 0/1",
                     l_ready, lq.size());
        end
        run_cycles(20);
        checks++;
        if (got.size() != 3) begin
            errors++;
            $display("FAIL order_count got %0d want 3", got.size());
        end
        for (int i = 0; i < 3; i++) begin
            if (i < got.size()) begin
                checks++;
                if (got[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL order_%0d got %0d want %0d",
                             i, got[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        configure(16'h0203);
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            lq.push_back(i);
            rq.push_back(10 * i);
        end
        run_cycles(8);
        checks++;
        if (lq.size() != 2 || rq.size() != 2) begin
            errors++;
            $display("FAIL bp_accepted got %0d/%0d left want 2/2",
                     lq.size(), rq.size());
        end
        checks++;
        if ({l_ready, r_ready} !== 2'b00) begin
            errors++;
            $display("FAIL bp_ready got %b want 00",
                     {l_ready, r_ready});
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'd11) begin
            errors++;
            $display("FAIL bp_head got %b/%0d want 1/11",
                     out_valid, out_data);
        end
        run_cycles(3);
        checks++;
        if (out_data !== 32'd11) begin
            errors++;
            $display("FAIL bp_stable got %0d want 11", out_data);
        end
        out_ready = 1'b1;
        run_cycles(12);
        checks++;
        if (got.size() != 6) begin
            errors++;
            $display("FAIL bp_count got %0d want 6", got.size());
        end
        for (int i = 0; i < 6; i++) begin
            if (i < got.size()) begin
                checks++;
                if (got[i] !== 32'(11 * (i + 1))) begin
                    errors++;
                    $display("FAIL bp_%0d got %0d want %0d",
                             i, got[i], 11 * (i + 1));
                end
            end
        end
        checks++;
        if (fire_cnt !== 16'd6) begin
            errors++;
            $display("FAIL bp_fire_cnt got %0d want 6", fire_cnt);
        end
    endtask

    task automatic test_drain();
        int ng;
        bit taken;
        ng = -1;
        taken = 1'b0;
        do_reset();
        configure(16'h0203);
        out_ready = 1'b0;
        lq = '{32'd1, 32'd2, 32'd3};
        rq = '{32'd4, 32'd5, 32'd6};
        run_cycles(8);
        checks++;
        if (fire_cnt !== 16'd2) begin
            errors++;
            $display("FAIL drain_pre_fire got %0d want 2", fire_cnt);
        end
        conf_valid = 1'b1;
        conf_data = 16'h0012;
        tick();
        checks++;
        if ({l_ready, r_ready, conf_ready} !== 3'b000) begin
            errors++;
            $display("FAIL drain_ready got %b want 000",
                     {l_ready, r_ready, conf_ready});
        end
        out_ready = 1'b1;
        for (int i = 0; i < 20 && !taken; i++) begin
            #1;
            if (out_valid) got.push_back(out_data);
            if (conf_ready) begin
                taken = 1'b1;
                ng = got.size();
            end
            tick();
        end
        conf_valid = 1'b0;
        checks++;
        if (!taken || ng != 3) begin
            errors++;
            $display("FAIL drain_conf taken %b after %0d want 1/3",
                     taken, ng);
        end
        checks++;
        if (got.size() != 3 || got[0] !== 32'd5 ||
            got[1] !== 32'd7 || got[2] !== 32'd9) begin
            errors++;
            $display("FAIL drain_results got %0d items want 5,7,9",
                     got.size());
        end
        got.delete();
        lq = '{32'd6, 32'hF0};
        rq = '{32'd3, 32'hFF};
        run_cycles(8);
        checks++;
        if (got.size() != 2 || got[0] !== 32'd5 ||
            got[1] !== 32'h0F) begin
            errors++;
            $display("FAIL drain_xor got %0d items want 5,0x0f",
                     got.size());
        end
        checks++;
        if (fire_cnt !== 16'd5) begin
            errors++;
            $display("FAIL drain_fire_cnt got %0d want 5", fire_cnt);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        configure(16'h0203);
        out_ready = 1'b0;
        lq = '{32'd1, 32'd2};
        rq = '{32'd1, 32'd2};
        run_cycles(6);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'd2) begin
            errors++;
            $display("FAIL mid_pre got %b/%0d want 1/2",
                     out_valid, out_data);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({out_valid, busy, l_ready, conf_ready} !== 4'b0001)
        begin
            errors++;
            $display("FAIL mid_rst got %b want 0001",
                     {out_valid, busy, l_ready, conf_ready});
        end
        rst = 1'b0;
        out_ready = 1'b1;
        got.delete();
        run_cycles(4);
        checks++;
        if (got.size() != 0 || l_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_stale got %0d/%b want 0/0",
                     got.size(), l_ready);
        end
        configure(16'h0203);
        lq = '{32'd3};
        rq = '{32'd4};
        run_cycles(6);
        checks++;
        if (got.size() != 1 || got[0] !== 32'd7) begin
            errors++;
            $display("FAIL mid_after got %0d items want 1 (7)",
                     got.size());
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        configure(16'h0203);
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            lq.push_back(i);
            rq.push_back(2 * i);
        end
        run_cycles(6);
        checks++;
        if (out_valid !== 1'b1 || l_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_full got %b/%b want 1/0",
                     out_valid, l_ready);
        end
        out_ready = 1'b1;
        run_cycles(14);
        checks++;
        if (got.size() != 8) begin
            errors++;
            $display("FAIL b2b_count got %0d want 8", got.size());
        end
        for (int i = 0; i < 8; i++) begin
            if (i < got.size()) begin
                checks++;
                if (got[i] !== 32'(3 * (i + 1))) begin
                    errors++;
                    $display("FAIL b2b_%0d got %0d want %0d",
                             i, got[i], 3 * (i + 1));
                end
            end
        end
        if (got_cyc.size() == 8) begin
            checks++;
            if (got_cyc[7] - got_cyc[0] != 7) begin
                errors++;
                $display("FAIL b2b_span got %0d want 7",
                         got_cyc[7] - got_cyc[0]);
            end
        end
        checks++;
        if (fire_cnt !== 16'd8) begin
            errors++;
            $display("FAIL b2b_fire_cnt got %0d want 8", fire_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_in_order();
        test_backpressure();
        test_drain();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/fu_issue_ctrl.md
FU_ISSUE_CTRL -- requirements
Module: fu_issue_ctrl

Interface
REQ-001 Parameter IN_DEPTH, default 2: entries per operand buffer, power of two, 2 or more.
REQ-002 Parameter OUT_DEPTH, default 2: entries in the result buffer, power of two, 2 or more.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 conf_valid  input  1  configuration word offered.
REQ-006 conf_data  input  16  function-unit configuration word (same encoding the FU consumes).
REQ-007 conf_ready  output  1  configuration word accepted this cycle when high together with conf_valid.
REQ-008 l_valid / l_data / l_ready  in / in / out  1 / 32 / 1  left-operand valid/ready port.
REQ-009 r_valid / r_data / r_ready  in / in / out  1 / 32 / 1  right-operand valid/ready port.
REQ-010 out_valid / out_data / out_ready  out / out / in  1 / 32 / 1  result valid/ready port.
REQ-011 busy  output  1  high when state is not IDLE or any buffer is non-empty.
REQ-012 fire_cnt  output  16  count of issued operations since reset; wraps at 0xFFFF->0.

Function
REQ-013 Transfer on any port shall occur only in a cycle where its valid and ready are both high.
REQ-014 FSM states shall be IDLE (unconfigured), RUN, DRAIN.
REQ-015 IDLE: conf_ready=1; l_ready=r_ready=0; accepted conf with conf_data[1:0]!=00 loads conf_reg and goes to RUN; with conf_data[1:0]==00 it stays in IDLE.
REQ-016 RUN: l_ready = left buffer not full; r_ready = right buffer not full; conf_ready=0; conf_valid=1 moves to DRAIN next cycle with no word consumed.
REQ-017 DRAIN: l_ready=r_ready=0; issue continues; conf_ready=1 only when both operand buffers and the result buffer are empty.
REQ-018 In DRAIN, the accepted conf word shall load conf_reg; the next state is RUN if conf_data[1:0]!=00, else IDLE.
REQ-019 Issue (fire) shall occur in RUN or DRAIN when both operand heads are valid and the result buffer has space, or is full but pops this cycle.
REQ-020 On fire, both heads shall pop, the FU result for (L head, R head, conf_reg) shall push to the result buffer, and fire_cnt shall increment.
REQ-021 Operands shall be matched strictly in arrival order per port; an unmatched head shall wait indefinitely.
REQ-022 Latency: operands accepted in cycle n give an earliest out_valid in cycle n+2; sustained throughput is 1 result per cycle when out_ready=1.
REQ-023 out_valid shall equal result buffer non-empty; out_data shall be the head entry, stable while out_valid=1 and out_ready=0.
REQ-024 Simultaneous push and pop on any buffer shall leave its count unchanged, including when the buffer is full or empty.
REQ-025 Pointers shall wrap modulo depth; no overflow or underflow under any legal stimulus.
REQ-026 conf_reg shall change only in IDLE or DRAIN, never while an operation is pending.

Reset
REQ-027 With rst=1 at a clock edge: state=IDLE; all buffers empty; conf_reg=0; fire_cnt=0.
REQ-028 Outputs during and after reset: out_valid=0, l_ready=r_ready=0, conf_ready=1, busy=0.
REQ-029 Reset mid-operation shall discard all buffered operands and results without emitting them.

Structure
REQ-030 The shared package dyser_pkg shall hold the state encoding (IDLE/RUN/DRAIN), the conf field positions, and the width constants; data width shall come from the existing config macro.
REQ-031 comp_logic shall be instantiated once as the datapath, with ready_in tied to fire; its done output is unused.
REQ-032 One sub-module, fu_fifo (parameterised depth and width), shall implement the operand and result buffers.

Verification
REQ-033 Reset, then conf 0x0203 (add), L=5 and R=7 in the same cycle, out_ready=1 -> out_data=12 two cycles later, and fire_cnt=1.
REQ-034 L stream 1,2,3 and R held off 10 cycles, then R 10,20,30 -> outputs 11,22,33 in order; l_ready=0 once the left buffer is full.
REQ-035 out_ready=0 with 6 operand pairs offered -> exactly 4 accepted and 2 results held (defaults); both ready signals low; out_data unchanged until out_ready=1.
REQ-036 conf_valid asserted with 3 results pending -> DRAIN; conf_ready stays 0 until the 3 results are popped; the new conf (0x0012, xor) then applies to later pairs.
REQ-037 rst pulsed with 2 buffered results -> out_valid=0 next cycle, state IDLE, and no stale result ever appears.
REQ-038 Full result buffer with out_ready=1 and a pair ready -> pop and fire in the same cycle; throughput is 1 per cycle with no bubble.
